// File: rtl/scc_pkg.sv
// scc_pkg: shared address map, FSM encoding and decode helper for the SCC register bridge.
package scc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RAM, S_CAPTURE, S_REG, S_ACK} state_t;
  typedef enum logic [1:0] {K_WAVE, K_REG, K_DEF, K_NONE} kind_t;
  localparam logic [7:0] SCC_WAVE_END  = 8'h7F;
  localparam logic [7:0] SCC_REG_END   = 8'h9F;
  localparam logic [7:0] SCC_DEF_BASE  = 8'hE0;
  localparam logic [7:0] SCCI_WAVE_END = 8'h9F;
  localparam logic [7:0] SCCI_REG_END  = 8'hBF;
  localparam logic [7:0] SCCI_DEF_END  = 8'hDF;
  localparam logic [2:0] CH_A = 3'd0;
  localparam logic [2:0] CH_B = 3'd1;
  localparam logic [2:0] CH_C = 3'd2;
  localparam logic [2:0] CH_D = 3'd3;
  localparam logic [2:0] CH_E = 3'd4;
  // Register windows start right after the wave area; a[3:0] is the register offset in both maps.
  function automatic kind_t decode(input logic [7:0] a, input logic scci);
    if (scci)
      return a <= SCCI_WAVE_END ? K_WAVE : a <= SCCI_REG_END ? K_REG : a <= SCCI_DEF_END ? K_DEF : K_NONE;
    return a <= SCC_WAVE_END ? K_WAVE : a <= SCC_REG_END ? K_REG : a >= SCC_DEF_BASE ? K_DEF : K_NONE;
  endfunction
endpackage

// File: rtl/scc_register_file.sv
// scc_register_file: channel registers, slot mux toward the mixer and counter-clear pulses.
module scc_register_file
  import scc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        we,
  input  logic        def_we,
  input  logic [3:0]  a,
  input  logic [7:0]  d,
  input  logic [2:0]  active,
  output logic [11:0] freq,
  output logic [3:0]  vol,
  output logic        en,
  output logic        wave_reset,
  output logic [4:0]  clear
);
  logic [4:0][11:0] fr, fr_n;
  logic [4:0][3:0]  vo, vo_n;
  logic [4:0]       mask, mask_n, clear_n;
  always_comb begin
    fr_n = fr;
    vo_n = vo;
    clear_n = '0;
    for (int i = 0; i < 5; i++) begin
      clear_n[i] = we && a < 4'd10 && a[3:1] == 3'(i);
      fr_n[i] = clear_n[i] ? (a[0] ? {d[3:0], fr[i][7:0]} : {fr[i][11:8], d}) : fr[i];
      vo_n[i] = (we && a == 4'(10 + i)) ? d[3:0] : vo[i];
    end
    mask_n = (we && a == 4'hF) ? d[4:0] : mask;
  end
  // The mux samples next-state values so a write shows up on the slot outputs right after REG.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr <= '0;
      vo <= '0;
      mask <= '0;
      wave_reset <= 1'b0;
      clear <= '0;
      freq <= '0;
      vol <= '0;
      en <= 1'b0;
    end else if (enable) begin
      fr <= fr_n;
      vo <= vo_n;
      mask <= mask_n;
      wave_reset <= def_we ? d[5] : wave_reset;
      clear <= clear_n;
      freq <= active < 3'd5 ? fr_n[active] : '0;
      vol <= active < 3'd5 ? vo_n[active] : '0;
      en <= active < 3'd5 && mask_n[active];
    end
  end
endmodule

// File: rtl/scc_register_bridge.sv
// scc_register_bridge: CPU window decode and access FSM driving the SCC mixer wave-RAM port and registers.
module scc_register_bridge
  import scc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        bus_req,
  input  logic        bus_wr,
  input  logic [7:0]  bus_a,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_ack,
  output logic        bus_busy,
  input  logic        reg_scci_enable,
  output logic [2:0]  sram_id,
  output logic [4:0]  sram_a,
  output logic [7:0]  sram_d,
  output logic        sram_oe,
  output logic        sram_we,
  input  logic [7:0]  sram_q,
  input  logic        sram_q_en,
  input  logic [2:0]  active,
  output logic [11:0] reg_frequency_count,
  output logic [3:0]  reg_volume,
  output logic        reg_enable,
  output logic        reg_wave_reset,
  output logic        clear_counter_a,
  output logic        clear_counter_b,
  output logic        clear_counter_c,
  output logic        clear_counter_d,
  output logic        clear_counter_e
);
  state_t     state, state_n;
  kind_t      lat_k;
  logic [7:0] lat_a, lat_d;
  logic       lat_wr, ram;
  logic [4:0] clear;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else if (enable) state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = bus_req ? (decode(bus_a, reg_scci_enable) == K_WAVE ? S_RAM : S_REG) : S_IDLE;
      S_RAM:     state_n = lat_wr ? S_ACK : S_CAPTURE;
      S_CAPTURE: state_n = sram_q_en ? S_ACK : S_CAPTURE;
      S_REG:     state_n = S_ACK;
      default:   state_n = S_IDLE;
    endcase
  end
  // The map is decoded once at request time so a later mode change cannot redirect an in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_a <= '0;
      lat_d <= '0;
      lat_wr <= 1'b0;
      lat_k <= K_NONE;
      bus_rdata <= '0;
    end else if (enable) begin
      if (state == S_IDLE && bus_req) begin
        lat_a <= bus_a;
        lat_d <= bus_wdata;
        lat_wr <= bus_wr;
        lat_k <= decode(bus_a, reg_scci_enable);
      end
      if (state == S_CAPTURE && sram_q_en) bus_rdata <= sram_q;
      if (state == S_REG && !lat_wr) bus_rdata <= 8'hFF;
    end
  end
  assign ram = state == S_RAM;
  always_comb begin
    sram_oe = ram && !lat_wr;
    sram_we = ram && lat_wr;
    sram_id = ram ? lat_a[7:5] : '0;
    sram_a = ram ? lat_a[4:0] : '0;
    sram_d = ram ? lat_d : '0;
    bus_ack = state == S_ACK;
    bus_busy = state != S_IDLE;
  end
  scc_register_file u_regs (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .we(state == S_REG && lat_wr && lat_k == K_REG),
    .def_we(state == S_REG && lat_wr && lat_k == K_DEF),
    .a(lat_a[3:0]),
    .d(lat_d),
    .active(active),
    .freq(reg_frequency_count),
    .vol(reg_volume),
    .en(reg_enable),
    .wave_reset(reg_wave_reset),
    .clear(clear)
  );
  assign clear_counter_a = clear[CH_A];
  assign clear_counter_b = clear[CH_B];
  assign clear_counter_c = clear[CH_C];
  assign clear_counter_d = clear[CH_D];
  assign clear_counter_e = clear[CH_E];
endmodule
